jk_ff_bank: RTL
===============

JK_FF_BANK -- requirements
Module: jk_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of flip-flop bits (legal range 1..32).
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into Q on reset.
REQ-003 The module SHALL have a single clock and a synchronous, active-high reset: ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  update enable; when low, Q holds (load still honoured).
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_val  input  WIDTH  value written to Q on load.
REQ-009 mode  input  2  00=JK, 01=T, 10=D, 11=COUNT.
REQ-010 J  input  WIDTH  per-bit J (JK mode); T input (T mode); D input (D mode).
REQ-011 K  input  WIDTH  per-bit K (JK mode only; ignored otherwise).
REQ-012 up  input  1  count direction in COUNT mode: 1=up, 0=down.
REQ-013 Q  output  WIDTH  registered state.
REQ-014 Qbar  output  WIDTH  bitwise complement of Q at all times.
REQ-015 tc  output  1  terminal-count flag, combinational from Q, mode, up, en.

Function
REQ-016 All state SHALL update only on the rising edge of clk; priority rst > load > en.
REQ-017 load=1 (rst=0): Q <= load_val next edge regardless of en and mode.
REQ-018 en=0, load=0: Q holds.
REQ-019 JK mode, per bit i: J=0,K=0 hold; J=1,K=0 set; J=0,K=1 clear; J=1,K=1 toggle.
REQ-020 T mode, per bit i: J[i]=1 toggles Q[i], J[i]=0 holds; K ignored.
REQ-021 D mode: Q <= J; K ignored.
REQ-022 COUNT mode, up=1: bit 0 always toggles; bit i>0 toggles iff Q[i-1:0] all ones (synchronous binary +1).
REQ-023 COUNT mode, up=0: bit 0 always toggles; bit i>0 toggles iff Q[i-1:0] all zeros (binary -1).
REQ-024 COUNT arithmetic SHALL be modulo 2^WIDTH: all-ones +1 wraps to 0; 0 -1 wraps to all-ones; no saturation.
REQ-025 tc SHALL be 1 iff mode=11 and en=1 and ((up=1 and Q all ones) or (up=0 and Q all zeros)); else 0.
REQ-026 A mode change SHALL take effect on the same edge it is sampled; no pipeline, latency 1 cycle from inputs to Q.
REQ-027 Changing up mid-count SHALL reverse direction from the current Q with no skipped or repeated value.
REQ-028 Simultaneous load and en: load wins; no toggle/count applied that cycle.
REQ-029 WIDTH=1 SHALL be supported; in COUNT mode the bit toggles every enabled cycle.
REQ-030 No combinational path SHALL exist from inputs to Q or Qbar; tc is the only combinational output.

Reset
REQ-031 rst=1 at a rising edge: Q <= RESET_VAL, Qbar <= ~RESET_VAL, regardless of load, en, mode.
REQ-032 Reset asserted mid-count SHALL abort the sequence; counting resumes from RESET_VAL on the first edge after rst deasserts.
REQ-033 tc after reset SHALL follow REQ-025 evaluated on RESET_VAL (default: 1 in COUNT mode, up=0, en=1).

Verification (WIDTH=4, RESET_VAL=0)
REQ-034 JK mode, en=1: J=0000,K=0000 -> hold 0000; J=1010,K=0000 -> 1010; J=0010,K=1000 -> 0010; J=1111,K=1111 -> 1101; Qbar always ~Q.
REQ-035 COUNT up, en=1 from 0 for 17 edges -> 1,2,...,15,0,1; tc=1 exactly while Q=1111.
REQ-036 COUNT down from load_val=0010: -> 0001,0000,1111,1110; tc=1 while Q=0000; toggle up at Q=1111 -> next 0000.
REQ-037 Priority: load=1,load_val=0110,en=1,mode=11 -> Q=0110 (no increment); then rst=1 with load=1 -> Q=0000.
REQ-038 en=0 in COUNT mode at Q=1111, up=1 -> Q holds 1111, tc=0; T mode J=0101 en=1 from 0000 -> 0101 -> 0000.
REQ-039 Mid-count reset: count up to 0111, assert rst one cycle -> 0000, deassert -> 0001,0010.

Source files
------------

// File: rtl/jk_ff_bank_if.sv
// rtl/jk_ff_bank_if.sv - control/data bundle for the JK flip-flop bank
// master drives controls and observes state; slave is the register bank
interface jk_ff_bank_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             up;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             tc;

  modport master (
    output en, load, load_val, mode, J, K, up,
    input  Q, Qbar, tc
  );

  modport slave (
    input  en, load, load_val, mode, J, K, up,
    output Q, Qbar, tc
  );
endinterface

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - WIDTH-bit register bank with JK, T, D and up/down count modes
// Q/Qbar are purely registered; tc is the only combinational output
module jk_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  jk_ff_bank_if.slave  bus
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_T     = 2'b01;
  localparam logic [1:0] MODE_D     = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] cnt_tgl;
  logic             carry;

  // A counter bit flips when every lower bit is at the wrap value for the direction.
  always_comb begin
    cnt_tgl = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_tgl[i] = carry;
      carry      = carry & (bus.up ? q_r[i] : ~q_r[i]);
    end
  end

  always_comb begin
    q_nxt = q_r;
    case (bus.mode)
      MODE_JK:    q_nxt = (bus.J & ~q_r) | (~bus.K & q_r);
      MODE_T:     q_nxt = q_r ^ bus.J;
      MODE_D:     q_nxt = bus.J;
      MODE_COUNT: q_nxt = q_r ^ cnt_tgl;
      default:    q_nxt = q_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (bus.load) begin
      q_r <= bus.load_val;
    end else if (bus.en) begin
      q_r <= q_nxt;
    end
  end

  assign bus.Q    = q_r;
  assign bus.Qbar = ~q_r;
  assign bus.tc   = (bus.mode == MODE_COUNT) && bus.en &&
                    (bus.up ? (&q_r) : ~(|q_r));

endmodule
